// File: rtl/mul_pipe_unit.sv
// mul_pipe_unit: two-stage LoongArch MUL.W/MULH.W/MULH.WU unit with valid/ready handshake
module mul_pipe_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  logic             r_s1_valid, r_s2_valid;
  logic [1:0]       r_s1_op;
  logic [TAG_W-1:0] r_s1_tag, r_s2_tag;
  logic [33:0]      r_s1_x, r_s1_y;
  logic [31:0]      r_s2_result;
  logic             w_sgn, w_accept, w_s2_go;
  logic [63:0]      w_prod;
  logic [31:0]      w_slice;
  always_comb begin
    w_sgn    = in_op == 2'b01;
    w_s2_go  = r_s1_valid & (~r_s2_valid | out_ready);
    in_ready = ~reset & ~flush & (~r_s1_valid | w_s2_go);
    w_accept = in_valid & in_ready;
    // only P[63:0] is consumed, so the 34x34 product is formed modulo 2^64
    w_prod   = $signed(r_s1_x) * $signed(r_s1_y);
    w_slice  = (r_s1_op == 2'b01 || r_s1_op == 2'b10) ? w_prod[63:32] : w_prod[31:0];
  end
  always_ff @(posedge clk) begin
    r_s1_valid <= (reset | flush) ? 1'b0 : w_accept ? 1'b1 : w_s2_go ? 1'b0 : r_s1_valid;
    r_s2_valid <= (reset | flush) ? 1'b0 : w_s2_go ? 1'b1 : out_ready ? 1'b0 : r_s2_valid;
  end
  always_ff @(posedge clk)
    if (w_accept) begin
      r_s1_op  <= in_op;
      r_s1_tag <= in_tag;
      r_s1_x   <= {{2{w_sgn & in_x[31]}}, in_x};
      r_s1_y   <= {{2{w_sgn & in_y[31]}}, in_y};
    end
  always_ff @(posedge clk)
    if (reset) begin
      r_s2_result <= '0;
      r_s2_tag    <= '0;
    end else if (w_s2_go & ~flush) begin
      r_s2_result <= w_slice;
      r_s2_tag    <= r_s1_tag;
    end
  assign out_valid  = r_s2_valid;
  assign out_result = r_s2_result;
  assign out_tag    = r_s2_tag;
  assign busy       = r_s1_valid | r_s2_valid;
endmodule

// File: tb/tb_mul_pipe_unit.sv
// tb_mul_pipe_unit: table vectors, directed handshake/flush/reset sequences and a random sweep
module tb_mul_pipe_unit;
  localparam int TAG_W = 5;
  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]       in_op;
  logic [31:0]      in_x, in_y, out_result;
  logic [TAG_W-1:0] in_tag, out_tag;
  mul_pipe_unit #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
  } exp_t;
  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
  } vec_t;
  exp_t q[$];
  vec_t vecs[8];
  int   checks = 0, errors = 0;
  logic acc, fire;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] model(logic [1:0] op, logic [31:0] x, logic [31:0] y);
    longint      a, b;
    logic [63:0] p;
    a = (op == 2'b01) ? longint'($signed(x)) : longint'({32'b0, x});
    b = (op == 2'b01) ? longint'($signed(y)) : longint'({32'b0, y});
    p = a * b;
    return (op == 2'b01 || op == 2'b10) ? p[63:32] : p[31:0];
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  // one clock with the current inputs; scoreboard tracks accepted ops in order
  task automatic tick();
    #1;
    acc  = in_valid & in_ready;
    fire = out_valid & out_ready;
    if (q.size() == 0) check("out_valid_when_empty", 32'(out_valid), 32'h0);
    else if (fire) begin
      check("out_result", out_result, q[0].res);
      check("out_tag", 32'(out_tag), 32'(q[0].tag));
    end
    @(posedge clk);
    if (fire && q.size() > 0) void'(q.pop_front());
    if (reset || flush) q.delete();
    else if (acc) q.push_back('{model(in_op, in_x, in_y), in_tag});
    #1;
  endtask
  task automatic run_vec(string name, logic [1:0] op, logic [31:0] x, logic [31:0] y,
                         logic [TAG_W-1:0] tag, logic [31:0] exp);
    in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag; out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_valid_lat1"}, 32'(out_valid), 32'h0);
    @(posedge clk); #1;
    check({name, "_valid_lat2"}, 32'(out_valid), 32'h1);
    check({name, "_result"}, out_result, exp);
    check({name, "_tag"}, 32'(out_tag), 32'(tag));
    @(posedge clk); #1;
    check({name, "_drained"}, 32'(out_valid), 32'h0);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int          na, nf, ops, cyc;
    logic [31:0] held;
    vecs[0] = '{"mulw_neg",   2'b00, 32'h0000_0003, 32'hFFFF_FFFB, 32'hFFFF_FFF1};
    vecs[1] = '{"mulhw_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2] = '{"mulhwu_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3] = '{"mulhw_m1",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4] = '{"op11_mulw",  2'b11, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A};
    vecs[5] = '{"mulw_wrap",  2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000};
    vecs[6] = '{"mulhwu_c",   2'b10, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};
    vecs[7] = '{"mulhw_c",    2'b01, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 2'b00; in_x = '0; in_y = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_tag", 32'(out_tag), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++)
      run_vec(vecs[i].name, vecs[i].op, vecs[i].x, vecs[i].y, TAG_W'(i + 3), vecs[i].exp);
    for (int c = 0; c < 7; c++) begin
      in_valid = c < 4; in_op = 2'b00; in_x = 32'(c + 2); in_y = 32'(c + 10);
      in_tag = TAG_W'(c + 1); out_ready = 1'b1;
      #1;
      if (c < 4) check("b2b_in_ready", 32'(in_ready), 32'h1);
      @(posedge clk); #1;
      if (c >= 1 && c <= 4) begin
        check("b2b_valid", 32'(out_valid), 32'h1);
        check("b2b_tag", 32'(out_tag), 32'(c));
        check("b2b_result", out_result, 32'((c + 1) * (c + 9)));
      end else check("b2b_idle", 32'(out_valid), 32'h0);
    end
    in_valid = 1'b0;
    na = 0; held = '0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 2'(na); in_x = 32'(100 + na); in_y = 32'(7 + na);
      in_tag = TAG_W'(10 + na);
      tick();
      if (acc) na++;
      if (i == 2) held = out_result;
    end
    check("bp_accepts", 32'(na), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'h0);
    check("bp_out_valid", 32'(out_valid), 32'h1);
    check("bp_busy", 32'(busy), 32'h1);
    check("bp_stable", out_result, held);
    check("bp_stable_val", out_result, 32'd700);
    out_ready = 1'b1; nf = 0;
    for (int i = 0; i < 10 && (na < 3 || q.size() > 0); i++) begin
      in_valid = na < 3; in_op = 2'(na); in_x = 32'(100 + na); in_y = 32'(7 + na);
      in_tag = TAG_W'(10 + na);
      tick();
      if (acc) na++;
      if (fire) nf++;
    end
    check("bp_total_accepts", 32'(na), 32'd3);
    check("bp_fires", 32'(nf), 32'd3);
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_op = 2'b00; in_x = 32'(20 + i); in_y = 32'h3; in_tag = TAG_W'(i);
      tick();
    end
    check("fl_full_busy", 32'(busy), 32'h1);
    check("fl_full_valid", 32'(out_valid), 32'h1);
    flush = 1'b1; in_x = 32'h55;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'h0);
    check("fl_busy", 32'(busy), 32'h0);
    run_vec("post_flush", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd9, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = 2'b00; in_x = 32'(30 + i); in_y = 32'h5; in_tag = TAG_W'(20 + i);
      tick();
    end
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_result", out_result, 32'h0);
    check("mid_rst_tag", 32'(out_tag), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    run_vec("post_rst", 2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 5'd17, 32'h0000_000F);
    ops = 0; cyc = 0;
    while (ops < 10000 && cyc < 60000) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_op = 2'($urandom_range(0, 3));
      in_x = pick(); in_y = pick();
      in_tag = TAG_W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      tick();
      if (acc) ops++;
      cyc++;
    end
    check("sweep_ops", 32'(ops), 32'd10000);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6 && q.size() > 0; i++) tick();
    check("sweep_drained", 32'(q.size()), 32'h0);
    check("sweep_idle_busy", 32'(busy), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
